// File: rtl/tone_pkg.sv
// Shared types and constants for the tone player: FSM states and the
// note-code to half-period divider table (computed for a 1 MHz clock).
package tone_pkg;

    localparam logic [3:0] NOTE_REST  = 4'd0;
    localparam int         NOTE_DIV_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LOAD,
        PLAY,
        ADV
    } state_e;

    // DIV = round(f_clk / (2*f_note)) - 1, f_clk = 1 MHz, equal temperament
    function automatic logic [NOTE_DIV_W-1:0] note_div(input logic [3:0] code);
        logic [NOTE_DIV_W-1:0] d;
        case (code)
            4'd1:    d = 12'd3821;  // C3
            4'd2:    d = 12'd3404;  // D3
            4'd3:    d = 12'd3033;  // E3
            4'd4:    d = 12'd2862;  // F3
            4'd5:    d = 12'd2550;  // G3
            4'd6:    d = 12'd2272;  // A3
            4'd7:    d = 12'd2024;  // B3
            4'd8:    d = 12'd1910;  // C4
            4'd9:    d = 12'd1702;  // D4
            4'd10:   d = 12'd1516;  // E4
            4'd11:   d = 12'd1431;  // F4
            4'd12:   d = 12'd1275;  // G4
            4'd13:   d = 12'd1135;  // A4
            4'd14:   d = 12'd1011;  // B4
            4'd15:   d = 12'd955;   // C5
            default: d = 12'd0;     // rest
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tone_div.sv
// Loadable half-period down-counter; the phase bit toggles each time the
// counter wraps, and the registered output is forced low while muted.
module tone_div
    import tone_pkg::*;
#(
    parameter int DIV_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             mute_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tone_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;
    logic             tone_q;

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        phase_d = phase_q;
        if (load_i) begin
            div_d   = div_i;
            cnt_d   = div_i;
            phase_d = 1'b0;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_d   = div_q;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Phase is kept while muted so a resumed note continues seamlessly
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            tone_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            tone_q  <= mute_i ? 1'b0 : phase_d;
        end
    end

    assign tone_o = tone_q;

endmodule

// File: rtl/tone_player.sv
// Melody ROM consumer: fetches note words, holds each for d+1 beats,
// drives the speaker square wave and pulses adv_o to step the ROM address.
module tone_player
    import tone_pkg::*;
#(
    parameter int DIV_W   = 12,
    parameter int ROM_LAT = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       beat_i,
    input  logic [7:0] rom_data_i,
    output logic       adv_o,
    output logic       spkr_o,
    output logic [3:0] tone_code_o
);

    localparam int                LAT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);

    state_e           state_q;
    logic [LAT_W-1:0] lat_q;
    logic [3:0]       beat_q;
    logic             adv_q;
    logic [3:0]       tone_code_q;

    logic             play_en;
    logic             div_load;
    logic             mute;
    logic [DIV_W-1:0] div_sel;

    assign play_en  = en_i && (state_q == PLAY);
    assign div_load = en_i && (state_q == LOAD);
    assign mute     = !en_i || (tone_code_q == NOTE_REST);
    assign div_sel  = DIV_W'(note_div(rom_data_i[3:0]));

    // Everything below advances only with en_i; a disabled cycle is a pure hold
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            beat_q      <= '0;
            adv_q       <= 1'b0;
            tone_code_q <= NOTE_REST;
        end else begin
            adv_q <= 1'b0;
            if (en_i) begin
                case (state_q)
                    IDLE: begin
                        lat_q   <= '0;
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        if (lat_q == LAT_LAST) begin
                            lat_q   <= '0;
                            state_q <= LOAD;
                        end else begin
                            lat_q <= lat_q + 1'b1;
                        end
                    end
                    LOAD: begin
                        tone_code_q <= rom_data_i[3:0];
                        beat_q      <= rom_data_i[7:4];
                        state_q     <= PLAY;
                    end
                    PLAY: begin
                        if (beat_i) begin
                            if (beat_q == '0) begin
                                adv_q   <= 1'b1;
                                state_q <= ADV;
                            end else begin
                                beat_q <= beat_q - 1'b1;
                            end
                        end
                    end
                    ADV: begin
                        lat_q   <= '0;
                        state_q <= WAIT;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    tone_div #(.DIV_W(DIV_W)) u_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (play_en),
        .load_i (div_load),
        .mute_i (mute),
        .div_i  (div_sel),
        .tone_o (spkr_o)
    );

    assign adv_o       = adv_q;
    assign tone_code_o = tone_code_q;

endmodule

// File: tb/tb_tone_player.sv
// Scenario bench for tone_player: expected timings and codes are queued
// when a note word is presented and popped when the DUT output is measured.
module tb_tone_player;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       beat = 1'b0;
    logic [7:0] rom = 8'h00;
    logic       adv;
    logic       spkr;
    logic [3:0] tone;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int adv_cnt = 0;
    int spkr_hi = 0;

    always #5 clk = ~clk;

    tone_player #(.DIV_W(12), .ROM_LAT(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .beat_i      (beat),
        .rom_data_i  (rom),
        .adv_o       (adv),
        .spkr_o      (spkr),
        .tone_code_o (tone)
    );

    always @(negedge clk) begin
        if (adv === 1'b1) adv_cnt++;
        if (spkr === 1'b1) spkr_hi++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        step();
        beat = 1'b0;
    endtask

    task automatic until_spkr(input logic lvl, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (spkr === lvl) begin
                n = i;
                return;
            end
        end
    endtask

    // Beats spaced 20 cycles apart until adv appears; -1 if it never does
    task automatic count_beats(input int max_beats, output int nb);
        nb = -1;
        for (int i = 1; i <= max_beats; i++) begin
            pulse_beat();
            if (adv === 1'b1) begin
                nb = i;
                return;
            end
            step(20);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        step(3);
        n_tests++; if (adv !== 1'b0) begin n_fail++; $display("FAIL reset_adv: got %b expected 0", adv); end
        n_tests++; if (spkr !== 1'b0) begin n_fail++; $display("FAIL reset_spkr: got %b expected 0", spkr); end
        n_tests++; if (tone !== 4'd0) begin n_fail++; $display("FAIL reset_tone: got %0d expected 0", tone); end
    endtask

    task automatic test_c4_single_beat();
        int n, e;
        rom = 8'h08;
        exp_q.push_back(8);
        exp_q.push_back(1911);
        exp_q.push_back(1911);
        exp_q.push_back(1);
        rst = 1'b0;
        en  = 1'b1;
        step(3);
        n_tests++; if (tone !== 4'd0) begin n_fail++; $display("FAIL c4_tone_before_load: got %0d expected 0", tone); end
        step();
        e = exp_q.pop_front();
        n_tests++; if (tone !== e[3:0]) begin n_fail++; $display("FAIL c4_tone: got %0d expected %0d", tone, e); end
        until_spkr(1'b1, 5000, n);
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL c4_first_toggle: got %0d expected %0d", n, e); end
        until_spkr(1'b0, 5000, n);
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL c4_half_period: got %0d expected %0d", n, e); end
        n_tests++; if (adv_cnt !== 0) begin n_fail++; $display("FAIL c4_no_early_adv: got %0d expected 0", adv_cnt); end
        count_beats(1, n);
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL c4_adv_after_beat: got %0d expected %0d", n, e); end
        step();
        n_tests++; if (adv !== 1'b0 || adv_cnt !== 1) begin n_fail++; $display("FAIL c4_adv_single: got adv=%b cnt=%0d expected 0/1", adv, adv_cnt); end
    endtask

    task automatic test_c3_four_beats();
        int n, e, a0;
        rom = 8'h31;
        exp_q.push_back(1);
        exp_q.push_back(3822);
        exp_q.push_back(3822);
        exp_q.push_back(4);
        step(2);
        n_tests++; if (tone !== 4'd8) begin n_fail++; $display("FAIL c3_tone_held_in_wait: got %0d expected 8", tone); end
        step();
        e = exp_q.pop_front();
        n_tests++; if (tone !== e[3:0]) begin n_fail++; $display("FAIL c3_tone: got %0d expected %0d", tone, e); end
        until_spkr(1'b1, 8000, n);
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL c3_first_toggle: got %0d expected %0d", n, e); end
        until_spkr(1'b0, 8000, n);
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL c3_half_period: got %0d expected %0d", n, e); end
        a0 = adv_cnt;
        count_beats(6, n);
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL c3_beat_count: got %0d expected %0d", n, e); end
        step();
        n_tests++; if (adv_cnt - a0 !== 1) begin n_fail++; $display("FAIL c3_adv_pulses: got %0d expected 1", adv_cnt - a0); end
    endtask

    task automatic test_rest();
        int n, e, s0;
        rom = 8'h10;
        exp_q.push_back(0);
        exp_q.push_back(2);
        step(3);
        e = exp_q.pop_front();
        n_tests++; if (tone !== e[3:0]) begin n_fail++; $display("FAIL rest_tone: got %0d expected %0d", tone, e); end
        s0 = spkr_hi;
        step(2000);
        count_beats(4, n);
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL rest_beat_count: got %0d expected %0d", n, e); end
        n_tests++; if (spkr_hi - s0 !== 0) begin n_fail++; $display("FAIL rest_spkr_silent: got %0d high cycles expected 0", spkr_hi - s0); end
    endtask

    // Entered with ADV visible; beat stays high across ADV, WAIT and LOAD
    task automatic test_beat_ignored();
        int n, e;
        rom = 8'h18;
        exp_q.push_back(8);
        exp_q.push_back(2);
        beat = 1'b1;
        step(4);
        beat = 1'b0;
        e = exp_q.pop_front();
        n_tests++; if (tone !== e[3:0]) begin n_fail++; $display("FAIL bign_tone: got %0d expected %0d", tone, e); end
        n_tests++; if (adv !== 1'b0) begin n_fail++; $display("FAIL bign_no_adv: got %b expected 0", adv); end
        count_beats(4, n);
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL bign_beat_count: got %0d expected %0d", n, e); end
        step();
    endtask

    task automatic test_en_drop();
        int n, m, e, bad;
        logic s_before;
        rom = 8'h2D;
        exp_q.push_back(13);
        exp_q.push_back(1135);
        exp_q.push_back(536);
        exp_q.push_back(2);
        step(3);
        e = exp_q.pop_front();
        n_tests++; if (tone !== e[3:0]) begin n_fail++; $display("FAIL en_tone: got %0d expected %0d", tone, e); end
        pulse_beat();
        until_spkr(1'b1, 3000, n);
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL en_first_toggle: got %0d expected %0d", n, e); end
        step(600);
        s_before = spkr;
        en  = 1'b0;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            beat = (i == 250);
            step();
            if (spkr !== 1'b0 || adv !== 1'b0) bad++;
        end
        beat = 1'b0;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL en_low_silent: got %0d active cycles expected 0", bad); end
        en = 1'b1;
        step();
        n_tests++; if (spkr !== s_before) begin n_fail++; $display("FAIL en_resume_level: got %b expected %b", spkr, s_before); end
        until_spkr(~s_before, 3000, m);
        n = (m < 0) ? -1 : m + 1;
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL en_resume_count: got %0d expected %0d", n, e); end
        count_beats(4, n);
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL en_beats_left: got %0d expected %0d", n, e); end
        step();
    endtask

    task automatic test_reset_mid_play();
        int n, e, a0;
        rom = 8'h0F;
        exp_q.push_back(15);
        exp_q.push_back(956);
        step(3);
        n_tests++; if (tone !== 4'd15) begin n_fail++; $display("FAIL rst_pre_tone: got %0d expected 15", tone); end
        until_spkr(1'b1, 2000, n);
        n_tests++; if (n < 0) begin n_fail++; $display("FAIL rst_pre_toggle: got timeout expected spkr high"); end
        rst = 1'b1;
        #1;
        n_tests++; if (spkr !== 1'b0 || adv !== 1'b0 || tone !== 4'd0) begin
            n_fail++; $display("FAIL rst_async_clear: got spkr=%b adv=%b tone=%0d expected 0/0/0", spkr, adv, tone);
        end
        step(3);
        rst = 1'b0;
        a0  = adv_cnt;
        step(3);
        n_tests++; if (tone !== 4'd0) begin n_fail++; $display("FAIL rst_wait_tone: got %0d expected 0", tone); end
        step();
        e = exp_q.pop_front();
        n_tests++; if (tone !== e[3:0]) begin n_fail++; $display("FAIL rst_reload_tone: got %0d expected %0d", tone, e); end
        until_spkr(1'b1, 2000, n);
        e = exp_q.pop_front();
        n_tests++; if (n !== e) begin n_fail++; $display("FAIL rst_first_toggle: got %0d expected %0d", n, e); end
        n_tests++; if (adv_cnt !== a0) begin n_fail++; $display("FAIL rst_no_adv: got %0d expected %0d", adv_cnt, a0); end
    endtask

    initial begin
        test_reset();
        test_c4_single_beat();
        test_c3_four_beats();
        test_rest();
        test_beat_ignored();
        test_en_drop();
        test_reset_mid_play();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
